// File: rtl/tx_link_blk_reader.sv
// Link block reader: streams one 4KB block per popped link number out of the data FIFO
// as a run of posted-write TLPs aimed at that link's current ring slot.
module tx_link_blk_reader #(
    parameter int PORTS      = 12,
    parameter int PORT_WIDTH = $clog2(PORTS),
    parameter int BLK_BEATS  = 128,
    parameter int SLOTS      = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [255:0]          iFIFO_DATA,
    input  logic                  iFIFO_EMPTY,
    output logic                  oFIFO_RD_ACK,
    input  logic [PORT_WIDTH-1:0] iLINK_NUMBER,
    input  logic                  iLINK_NUM_EMPTY,
    output logic                  oBLK_DONE_PULSE,
    output logic                  oTX_REQ,
    input  logic                  iTX_GNT,
    output logic [63:0]           oTX_ADDR,
    output logic [9:0]            oTX_LEN,
    output logic [255:0]          oTX_DATA,
    output logic                  oTX_DATA_V,
    output logic                  oTX_SOP,
    output logic                  oTX_EOP,
    input  logic                  iTX_READY,
    input  logic                  iREG_ENABLE,
    input  logic [63:0]           iREG_BASE_ADDR,
    input  logic [1:0]            iREG_MPS,
    output logic                  oHIP_BLK_DONE,
    output logic [PORT_WIDTH-1:0] oHIP_LINK_NUMBER,
    output logic [2:0]            oREG_PS
);
    localparam int SLOT_W = $clog2(SLOTS);

    // IDLE wait for work | LOAD latch link/mps/addr | REQ ask HIP | DATA stream beats | DONE bump slot
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        REQ  = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  rst_done_q, rst_done_d;
    logic [PORT_WIDTH-1:0] link_q, link_d;
    logic [1:0]            mps_q, mps_d;
    logic [7:0]            beat_ctr_q, beat_ctr_d;
    logic [63:0]           tlp_addr_q, tlp_addr_d;
    logic [SLOT_W-1:0]     slot_q [PORTS];
    logic [SLOT_W-1:0]     slot_d [PORTS];

    logic [7:0]        bpt;
    logic [7:0]        pos;
    logic              is_sop, is_eop, last_beat;
    logic              beat_v, beat_acc;
    logic [SLOT_W-1:0] slot_cur;
    logic [63:0]       ring_off;

    always_comb begin
        unique case (mps_q)
            2'd0:    bpt = 8'd4;
            2'd1:    bpt = 8'd8;
            default: bpt = 8'd16;
        endcase
    end

    // Beat position inside the TLP falls out of the block beat count since bpt divides it.
    assign pos       = beat_ctr_q & (bpt - 8'd1);
    assign is_sop    = (pos == 8'd0);
    assign is_eop    = (pos == bpt - 8'd1);
    assign last_beat = ({1'b0, beat_ctr_q} + 9'd1) == 9'(BLK_BEATS);
    assign beat_v    = (state_q == DATA) && !iFIFO_EMPTY;
    assign beat_acc  = beat_v && iTX_READY;

    assign slot_cur = (32'(iLINK_NUMBER) < PORTS) ? slot_q[iLINK_NUMBER] : '0;
    assign ring_off = 64'({iLINK_NUMBER, slot_cur, 12'h000});

    assign oTX_DATA_V       = beat_v;
    assign oFIFO_RD_ACK     = beat_acc;
    assign oTX_SOP          = beat_v && is_sop;
    assign oTX_EOP          = beat_v && is_eop;
    assign oTX_DATA         = iFIFO_DATA;
    assign oTX_REQ          = (state_q == REQ);
    assign oTX_ADDR         = tlp_addr_q;
    assign oTX_LEN          = {bpt[6:0], 3'b000};
    assign oBLK_DONE_PULSE  = (state_q == DONE);
    assign oHIP_BLK_DONE    = (state_q == DONE);
    assign oHIP_LINK_NUMBER = link_q;
    assign oREG_PS          = state_q;

    always_comb begin
        state_d    = state_q;
        rst_done_d = 1'b1;
        link_d     = link_q;
        mps_d      = mps_q;
        beat_ctr_d = beat_ctr_q;
        tlp_addr_d = tlp_addr_q;
        slot_d     = slot_q;
        unique case (state_q)
            IDLE: begin
                if (rst_done_q && iREG_ENABLE && !iLINK_NUM_EMPTY && !iFIFO_EMPTY)
                    state_d = LOAD;
            end
            LOAD: begin
                link_d     = iLINK_NUMBER;
                mps_d      = iREG_MPS;
                beat_ctr_d = 8'd0;
                tlp_addr_d = iREG_BASE_ADDR + ring_off;
                state_d    = REQ;
            end
            REQ: begin
                if (iTX_GNT)
                    state_d = DATA;
            end
            DATA: begin
                if (beat_acc) begin
                    beat_ctr_d = beat_ctr_q + 8'd1;
                    if (is_eop) begin
                        if (last_beat) begin
                            state_d = DONE;
                        end else begin
                            tlp_addr_d = tlp_addr_q + (64'(bpt) << 5);
                            state_d    = REQ;
                        end
                    end
                end
            end
            DONE: begin
                if (32'(link_q) < PORTS)
                    slot_d[link_q] = (slot_q[link_q] == SLOT_W'(SLOTS - 1)) ? '0
                                                                            : slot_q[link_q] + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rst_done_q holds off the first LOAD until one full cycle after reset release.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            link_q     <= '0;
            mps_q      <= 2'd0;
            beat_ctr_q <= 8'd0;
            tlp_addr_q <= 64'd0;
            for (int i = 0; i < PORTS; i++)
                slot_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= rst_done_d;
            link_q     <= link_d;
            mps_q      <= mps_d;
            beat_ctr_q <= beat_ctr_d;
            tlp_addr_q <= tlp_addr_d;
            slot_q     <= slot_d;
        end
    end
endmodule

// File: tb/tb_tx_link_blk_reader.sv
// Directed bench for tx_link_blk_reader: FIFO/link-queue model, TLP capture and
// hand-computed ring addresses per block.
module tb_tx_link_blk_reader;
    logic         iCLK = 1'b0;
    logic         iRST_N;
    logic [255:0] iFIFO_DATA;
    logic         iFIFO_EMPTY;
    logic         oFIFO_RD_ACK;
    logic [3:0]   iLINK_NUMBER;
    logic         iLINK_NUM_EMPTY;
    logic         oBLK_DONE_PULSE;
    logic         oTX_REQ;
    logic         iTX_GNT;
    logic [63:0]  oTX_ADDR;
    logic [9:0]   oTX_LEN;
    logic [255:0] oTX_DATA;
    logic         oTX_DATA_V;
    logic         oTX_SOP;
    logic         oTX_EOP;
    logic         iTX_READY;
    logic         iREG_ENABLE;
    logic [63:0]  iREG_BASE_ADDR;
    logic [1:0]   iREG_MPS;
    logic         oHIP_BLK_DONE;
    logic [3:0]   oHIP_LINK_NUMBER;
    logic [2:0]   oREG_PS;

    tx_link_blk_reader dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iFIFO_DATA(iFIFO_DATA), .iFIFO_EMPTY(iFIFO_EMPTY), .oFIFO_RD_ACK(oFIFO_RD_ACK),
        .iLINK_NUMBER(iLINK_NUMBER), .iLINK_NUM_EMPTY(iLINK_NUM_EMPTY),
        .oBLK_DONE_PULSE(oBLK_DONE_PULSE), .oTX_REQ(oTX_REQ), .iTX_GNT(iTX_GNT),
        .oTX_ADDR(oTX_ADDR), .oTX_LEN(oTX_LEN), .oTX_DATA(oTX_DATA), .oTX_DATA_V(oTX_DATA_V),
        .oTX_SOP(oTX_SOP), .oTX_EOP(oTX_EOP), .iTX_READY(iTX_READY),
        .iREG_ENABLE(iREG_ENABLE), .iREG_BASE_ADDR(iREG_BASE_ADDR), .iREG_MPS(iREG_MPS),
        .oHIP_BLK_DONE(oHIP_BLK_DONE), .oHIP_LINK_NUMBER(oHIP_LINK_NUMBER), .oREG_PS(oREG_PS)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    int     link_q[$];
    longint addr_q[$];
    longint len_q[$];
    int dseq = 0, davail = 0;
    int acks, sops, eops, dones, done_link, done_err;
    int order_err, sop_err, ack_err, v_empty, req_cycles, blk_beat;
    int exp_bpt = 8;

    localparam longint BASE = 64'h1_0000_0000;

    function automatic logic [255:0] beat_data(input int s);
        return {8{s ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rnd);
        bit gap;
        gap             = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
        iTX_READY       = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        iFIFO_EMPTY     = (davail <= 0) || gap;
        iFIFO_DATA      = beat_data(dseq);
        iLINK_NUM_EMPTY = (link_q.size() == 0);
        iLINK_NUMBER    = (link_q.size() > 0) ? 4'(link_q[0]) : 4'd0;
        iTX_GNT         = oTX_REQ && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    endtask

    task automatic clear_stats();
        acks = 0; sops = 0; eops = 0; dones = 0; done_link = -1; done_err = 0;
        order_err = 0; sop_err = 0; ack_err = 0; v_empty = 0; req_cycles = 0; blk_beat = 0;
        addr_q.delete();
        len_q.delete();
    endtask

    task automatic cyc(input bit rnd);
        bit acc, ack, pop;
        @(negedge iCLK);
        acc = oTX_DATA_V && iTX_READY;
        ack = oFIFO_RD_ACK;
        if (ack !== acc) ack_err++;
        if (oTX_DATA_V && iFIFO_EMPTY) v_empty++;
        if (oTX_DATA_V) begin
            if (oTX_SOP !== ((blk_beat % exp_bpt) == 0)) sop_err++;
            if (oTX_EOP !== ((blk_beat % exp_bpt) == exp_bpt - 1)) sop_err++;
        end
        if (acc) begin
            if (oTX_DATA !== beat_data(dseq)) order_err++;
            if (oTX_SOP) sops++;
            if (oTX_EOP) eops++;
            blk_beat++;
        end
        if (oTX_REQ) begin
            req_cycles++;
            if (iTX_GNT) begin
                addr_q.push_back(longint'(oTX_ADDR));
                len_q.push_back(longint'(oTX_LEN));
            end
        end
        pop = oBLK_DONE_PULSE;
        if (pop) begin
            dones++;
            done_link = int'(oHIP_LINK_NUMBER);
            if (oHIP_BLK_DONE !== 1'b1) done_err++;
        end
        @(posedge iCLK);
        #1;
        if (ack) begin dseq++; davail--; acks++; end
        if (pop && link_q.size() > 0) void'(link_q.pop_front());
        drive(rnd);
    endtask

    task automatic load_blk(input int link);
        link_q.push_back(link);
        davail += 128;
        drive(0);
    endtask

    // act: 1 = switch MPS to 2, 2 = drop enable, 3 = assert reset (block then abandoned)
    task automatic run_block(input int budget, input bit rnd, input int act_at, input int act);
        int n;
        bit acted, stop;
        clear_stats();
        n = 0; acted = 0; stop = 0;
        while (dones == 0 && n < budget && !stop) begin
            cyc(rnd);
            n++;
            if (!acted && act != 0 && acks >= act_at) begin
                acted = 1;
                if (act == 1) iREG_MPS = 2'd2;
                if (act == 2) iREG_ENABLE = 1'b0;
                if (act == 3) begin iRST_N = 1'b0; stop = 1; end
            end
        end
        if (act != 3) chk("block_timeout", longint'(n < budget), 1);
    endtask

    task automatic check_block(input string tag, input int ntlp, input longint base,
                               input longint step, input longint len, input int link);
        int bad;
        bad = 0;
        chk({tag, "_ntlp"}, addr_q.size(), ntlp);
        chk({tag, "_start"}, addr_q.size() > 0 ? addr_q[0] : -1, base);
        for (int i = 0; i < addr_q.size(); i++) begin
            if (addr_q[i] !== base + i * step) bad++;
            if (len_q[i] !== len) bad++;
        end
        chk({tag, "_addr_len_bad"}, bad, 0);
        chk({tag, "_acks"}, acks, 128);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_done_link"}, done_link, link);
        chk({tag, "_sops"}, sops, ntlp);
        chk({tag, "_eops"}, eops, ntlp);
        chk({tag, "_order"}, order_err, 0);
        chk({tag, "_sop_eop_pos"}, sop_err, 0);
        chk({tag, "_ack_rule"}, ack_err, 0);
        chk({tag, "_v_empty"}, v_empty + done_err, 0);
    endtask

    initial begin
        iRST_N         = 1'b0;
        iREG_ENABLE    = 1'b1;
        iREG_MPS       = 2'd1;
        iREG_BASE_ADDR = BASE;
        iTX_GNT        = 1'b0;
        iTX_READY      = 1'b1;
        load_blk(3);
        repeat (2) @(posedge iCLK);
        #1;
        chk("reset_outs", {oTX_REQ, oTX_DATA_V, oTX_SOP, oTX_EOP, oFIFO_RD_ACK,
                           oBLK_DONE_PULSE, oHIP_BLK_DONE}, 0);
        chk("reset_ps", oREG_PS, 0);
        chk("reset_link", oHIP_LINK_NUMBER, 0);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        chk("first_edge_idle", oREG_PS, 0);

        // Block 1: link 3, MPS=1, slot 0
        exp_bpt = 8;
        run_block(3000, 0, 0, 0);
        check_block("blk1", 16, BASE + 64'h3_0000, 64'h100, 64, 3);

        // Blocks 2..17 on link 3 walk the ring and wrap
        for (int k = 2; k <= 17; k++) begin
            load_blk(3);
            run_block(3000, 0, 0, 0);
            chk($sformatf("blk%0d_start", k), addr_q.size() > 0 ? addr_q[0] : -1,
                BASE + 64'h3_0000 + longint'((k - 1) % 16) * 64'h1000);
            chk($sformatf("blk%0d_acks", k), acks, 128);
        end

        load_blk(5);
        run_block(3000, 0, 0, 0);
        check_block("link5", 16, BASE + 64'h5_0000, 64'h100, 64, 5);

        // Random backpressure and FIFO gaps; link 3 now at slot 1
        load_blk(3);
        run_block(3000, 1, 0, 0);
        check_block("rnd", 16, BASE + 64'h3_1000, 64'h100, 64, 3);

        // MPS change mid-block only affects the next block
        iREG_MPS = 2'd0;
        exp_bpt  = 4;
        load_blk(3);
        run_block(3000, 0, 50, 1);
        check_block("mps0", 32, BASE + 64'h3_2000, 64'h80, 32, 3);
        exp_bpt = 16;
        load_blk(3);
        run_block(3000, 0, 0, 0);
        check_block("mps2", 8, BASE + 64'h3_3000, 64'h200, 128, 3);

        // Enable low holds IDLE; dropping it mid-block does not abort
        iREG_ENABLE = 1'b0;
        load_blk(6);
        clear_stats();
        repeat (20) cyc(0);
        chk("dis_ps", oREG_PS, 0);
        chk("dis_req", req_cycles, 0);
        iREG_ENABLE = 1'b1;
        run_block(3000, 0, 10, 2);
        check_block("en_drop", 8, BASE + 64'h6_0000, 64'h200, 128, 6);
        iREG_ENABLE = 1'b1;

        // Reset at beat 40 of a link 3 block (slot 4)
        load_blk(3);
        run_block(3000, 0, 40, 3);
        #1;
        chk("midrst_outs", {oTX_REQ, oTX_DATA_V, oTX_SOP, oTX_EOP, oFIFO_RD_ACK,
                            oBLK_DONE_PULSE, oHIP_BLK_DONE}, 0);
        chk("midrst_ps", oREG_PS, 0);
        chk("midrst_link", oHIP_LINK_NUMBER, 0);
        chk("midrst_acks", acks, 40);
        repeat (2) @(posedge iCLK);
        #1;
        link_q.delete();
        davail = 0;
        load_blk(3);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        chk("midrst_first_edge_idle", oREG_PS, 0);
        run_block(3000, 0, 0, 0);
        check_block("post_rst", 8, BASE + 64'h3_0000, 64'h200, 128, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_link_blk_reader.md
TX_LINK_BLK_READER -- requirements
Module: tx_link_blk_reader

Interface
REQ-001 Parameters SHALL be:
- PORTS, default 12, number of links.
- PORT_WIDTH, default $clog2(PORTS), link number width.
- BLK_BEATS, default 128, 256-bit beats per 4KB block.
- SLOTS, default 16, 4KB ring slots per link.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- iCLK  in  1  sole clock.
- iRST_N  in  1  reset, asynchronous, active-low.
- iFIFO_DATA  in  256  show-ahead head of the link arbiter data FIFO.
- iFIFO_EMPTY  in  1  data FIFO empty.
- oFIFO_RD_ACK  out  1  pops one data beat.
- iLINK_NUMBER  in  PORT_WIDTH  show-ahead head of the link-number FIFO.
- iLINK_NUM_EMPTY  in  1  link-number FIFO empty.
- oBLK_DONE_PULSE  out  1  pops one link number.
- oTX_REQ  out  1  TLP request to the HIP arbiter.
- iTX_GNT  in  1  TLP grant.
- oTX_ADDR  out  64  TLP byte address.
- oTX_LEN  out  10  TLP length in DW.
- oTX_DATA  out  256  payload beat.
- oTX_DATA_V  out  1  payload valid.
- oTX_SOP  out  1  first beat of a TLP.
- oTX_EOP  out  1  last beat of a TLP.
- iTX_READY  in  1  beat accepted when oTX_DATA_V is also high; ready latency 0.
- iREG_ENABLE  in  1  allows a new block to start.
- iREG_BASE_ADDR  in  64  ring base address, 1MB aligned.
- iREG_MPS  in  2  payload size: 0 = 128B, 1 = 256B, 2 = 512B, 3 treated as 512B.
- oHIP_BLK_DONE  out  1  block-complete pulse.
- oHIP_LINK_NUMBER  out  PORT_WIDTH  link number of the completed block.
- oREG_PS  out  3  FSM state encoding, for debug.

Function
REQ-003 The FSM SHALL have states IDLE=0, LOAD=1, REQ=2, DATA=3, DONE=4.

REQ-004 IDLE->LOAD SHALL occur when iREG_ENABLE & ~iLINK_NUM_EMPTY & ~iFIFO_EMPTY; otherwise the FSM stays in IDLE.

REQ-005 In LOAD (one cycle) the block SHALL latch:
- link = iLINK_NUMBER;
- mps = iREG_MPS;
- beat_ctr = 0;
- tlp_addr = iREG_BASE_ADDR + {link, slot[link], 12'h000}.
It SHALL then go to REQ.

REQ-006 beats_per_tlp SHALL be 4, 8 or 16 for mps 0, 1, 2/3 respectively, and oTX_LEN SHALL be 32, 64 or 128 DW to match.

REQ-007 In REQ, oTX_REQ SHALL be 1 with oTX_ADDR = tlp_addr held stable; on iTX_GNT=1 the FSM SHALL go to DATA, and oTX_REQ SHALL deassert the following cycle.

REQ-008 In DATA:
- oTX_DATA_V = ~iFIFO_EMPTY;
- oTX_DATA = iFIFO_DATA, combinational pass-through;
- oFIFO_RD_ACK = oTX_DATA_V & iTX_READY.

REQ-009 oTX_SOP SHALL be 1 on the first beat of each TLP. oTX_EOP SHALL be 1 on beat beats_per_tlp-1 of each TLP.

REQ-010 Each accepted beat SHALL increment beat_ctr (8 bits). On an accepted EOP beat:
- if beat_ctr+1 == BLK_BEATS, the FSM goes to DONE;
- otherwise tlp_addr += beats_per_tlp*32 and the FSM returns to REQ.

REQ-011 A FIFO-empty stall SHALL drop oTX_DATA_V and hold beat_ctr, SOP/EOP position and the data order. No ack is issued while empty.

REQ-012 DONE (one cycle) SHALL:
- pulse oBLK_DONE_PULSE=1 and oHIP_BLK_DONE=1, with oHIP_LINK_NUMBER=link;
- set slot[link] = (slot[link]+1) mod SLOTS;
- go to IDLE.

REQ-013 Per-link slot counters SHALL be log2(SLOTS) bits wide and wrap from SLOTS-1 to 0. Only the completing link's counter changes.

REQ-014 iREG_MPS and iREG_BASE_ADDR changes SHALL take effect only at the next LOAD.

REQ-015 iREG_ENABLE deasserted mid-block SHALL NOT abort the block; it SHALL only block the next IDLE->LOAD.

REQ-016 oTX_DATA_V, oFIFO_RD_ACK, oTX_SOP and oTX_EOP SHALL be 0 outside DATA. oTX_REQ SHALL be 0 outside REQ.

REQ-017 Exactly BLK_BEATS oFIFO_RD_ACK pulses and one oBLK_DONE_PULSE SHALL occur per block.

Reset
REQ-018 Reset SHALL force the following, asynchronously and from any state including mid-DATA:
- FSM to IDLE;
- beat_ctr, tlp_addr and all slot counters to 0;
- oTX_REQ, oTX_DATA_V, oTX_SOP, oTX_EOP, oFIFO_RD_ACK, oBLK_DONE_PULSE and oHIP_BLK_DONE to 0;
- oHIP_LINK_NUMBER to 0 and oREG_PS to 0.

REQ-019 After reset release, the first LOAD SHALL NOT occur before the second rising iCLK edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single block, link 3, MPS=1, base 0x1_0000_0000, iTX_READY=1 -> 16 TLPs at addresses 0x1_0003_0000..0x1_0003_0F00 in 0x100 steps, oTX_LEN=64, 128 acks, one oBLK_DONE_PULSE, oHIP_LINK_NUMBER=3.
- 17 consecutive blocks on link 3 -> block 2 starts at 0x1_0003_1000, block 16 at 0x1_0003_F000, block 17 wraps to 0x1_0003_0000; the link 5 slot counter stays 0.
- Random iTX_READY backpressure plus FIFO-empty gaps mid-TLP -> payload order identical to FIFO order, no oTX_DATA_V while empty, SOP/EOP count 16/16, 128 acks.
- iREG_MPS changed 0->2 mid-block -> current block keeps 32 TLPs of 32 DW; next block uses 8 TLPs of 128 DW.
- iREG_ENABLE=0 with both FIFOs non-empty -> FSM stays in IDLE with no oTX_REQ; deasserting enable mid-DATA still completes 128 beats.
- iRST_N low during beat 40 of DATA -> all outputs 0 immediately and slot counters 0; the next block on the same link uses slot 0.
